fft_bitrev_loader: RTL and testbench
====================================

Name: fft_bitrev_loader

Overview:
- Controls the FFT input buffer memory: write/read addresses, write enable, data routing.
- Accepts a stream of complex time-domain samples and writes each N-sample symbol into the buffer at bit-reversed addresses.
- Then reads the buffer out in natural order to the radix-2 FFT core, ping-ponging between fill and drain phases.
- Sits between cyclic-prefix removal (upstream) and the FFT butterfly stage (downstream).

Parameters:
- log2N, 6, address width; N must equal 2**log2N
- Q, 16, bits per real/imag component (two's complement)
- N, 64, FFT size in samples per symbol

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  loader accepting samples (high only in FILL)
- in_data_r  in  Q  input sample, real
- in_data_i  in  Q  input sample, imag
- mem_addra  out  log2N  buffer write address
- mem_addrb  out  log2N  buffer read address
- mem_we  out  1  buffer write enable
- mem_data_r  out  Q  buffer write data, real
- mem_data_i  out  Q  buffer write data, imag
- mem_q_r  in  Q  buffer registered read data, real
- mem_q_i  in  Q  buffer registered read data, imag
- out_valid  out  1  output sample valid
- out_last  out  1  marks sample N-1 of a symbol
- out_data_r  out  Q  output sample, real
- out_data_i  out  Q  output sample, imag
- frame_done  out  1  one-cycle pulse when a symbol has been fully written

Behaviour:
- Buffer contract (the buffer memory this block drives):
  - On a clk edge with we=1, it writes mem[addra] and holds its read register.
  - With we=0, its read register loads mem[addrb], giving 1-cycle read latency.
  - Its reset clears only the read register.
- Reset (rst_n=1, async):
  - state=FILL; wcnt=0; rcnt=0.
  - out_valid=0, out_last=0, frame_done=0.
  - in_ready=1 after reset release.
  - Reset mid-symbol discards the partial symbol; buffer contents are not cleared.
- FSM states: FILL, DRAIN.
- FILL:
  - in_ready=1.
  - mem_we = in_valid, combinational.
  - mem_addra = bitrev(wcnt) over log2N bits, combinational (bit k of wcnt goes to bit log2N-1-k).
  - mem_data_r/i = in_data_r/i, combinational pass-through.
  - wcnt increments on each accepted sample; idle cycles (in_valid=0) hold wcnt.
  - On acceptance with wcnt=N-1: wcnt wraps to 0, frame_done=1 next cycle, state goes to DRAIN.
- DRAIN:
  - in_ready=0, mem_we=0; in_valid is ignored and samples are dropped (upstream must honour in_ready).
  - mem_addrb = rcnt; rcnt increments every cycle from 0 to N-1 with no stalls.
  - After issuing rcnt=N-1: rcnt wraps to 0, state goes to FILL.
- mem_addrb in FILL: held at 0. mem_addra in DRAIN: bitrev(wcnt)=0, with we=0.
- Output timing:
  - out_valid = registered (state==DRAIN); out_last = registered (state==DRAIN && rcnt==N-1).
  - out_data_r/i = mem_q_r/i pass-through, meaningful only when out_valid=1.
  - First valid output appears 1 cycle after DRAIN entry. Symbol latency from the last input accept to the first output is 2 cycles.
- Boundary at the DRAIN-to-FILL edge:
  - The last output (out_last=1) is presented in the first FILL cycle.
  - A write may occur in that same cycle; the buffer holds its read register while we=1, so that output stays correct.
- Throughput: one symbol per N+fill cycles. No output backpressure; downstream must accept every out_valid cycle.
- Arithmetic: no data modification; the loader moves data bit-exactly.

Test Plan:
- Bench setup: bench instantiates the buffer model per the buffer contract above.
- N=64, continuous in_valid, in_data_r=k, in_data_i=-k for k=0..63:
  - frame_done pulses once.
  - 2 cycles after the last accept, the output sequence is bitrev(k): 0,32,16,48,8,...,63; imag values are the negatives.
  - out_last is high only on the 64th output.
- in_valid toggling 1,0,0,1... across a symbol -> wcnt advances only on accepts; output identical to the continuous case.
- in_valid held high through DRAIN:
  - in_ready=0 and mem_we=0 for exactly 64 cycles.
  - No buffer writes occur; the next symbol starts at mem_addra=0 in the first FILL cycle.
- Two back-to-back symbols (values 0..63, then 100..163) -> the second output symbol is 100+bitrev(k) with no corruption at the DRAIN-to-FILL boundary.
- Assert rst_n after 20 accepts, then release and send a full symbol:
  - out_valid=0 during reset.
  - Output is exactly the new symbol, bit-reversed; no residue from the partial one.
- Extreme values in_data_r=16'h8000, in_data_i=16'h7FFF -> output bit-exact.

Source files
------------

// File: rtl/fft_bitrev_loader.sv
// FFT input buffer loader: writes each N-sample symbol into the buffer at
// bit-reversed addresses (FILL), then reads it out in natural order (DRAIN).
module fft_bitrev_loader #(
  parameter int log2N = 6,
  parameter int Q     = 16,
  parameter int N     = 64   // must equal 2**log2N
) (
  input  logic             clk,
  input  logic             rst_n,     // active-high asynchronous reset
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Q-1:0]     in_data_r,
  input  logic [Q-1:0]     in_data_i,
  output logic [log2N-1:0] mem_addra,
  output logic [log2N-1:0] mem_addrb,
  output logic             mem_we,
  output logic [Q-1:0]     mem_data_r,
  output logic [Q-1:0]     mem_data_i,
  input  logic [Q-1:0]     mem_q_r,
  input  logic [Q-1:0]     mem_q_i,
  output logic             out_valid,
  output logic             out_last,
  output logic [Q-1:0]     out_data_r,
  output logic [Q-1:0]     out_data_i,
  output logic             frame_done
);

  typedef enum logic {FILL, DRAIN} state_t;

  localparam logic [log2N-1:0] LAST = log2N'(N - 1);
  localparam logic [log2N-1:0] ONE  = log2N'(1);

  state_t           state_q, state_d;
  logic [log2N-1:0] wcnt_q, wcnt_d;
  logic [log2N-1:0] rcnt_q, rcnt_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             frame_done_q, frame_done_d;

  // State and counter registers; reset drops any partially written symbol.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= FILL;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state, counters and memory-side controls.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    rcnt_d       = rcnt_q;
    frame_done_d = 1'b0;
    in_ready     = 1'b0;
    mem_we       = 1'b0;
    mem_addrb    = '0;
    // wcnt rests at 0 during DRAIN, so this also yields address 0 there
    mem_addra    = '0;
    for (int k = 0; k < log2N; k++) mem_addra[log2N-1-k] = wcnt_q[k];
    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        mem_we   = in_valid;
        if (in_valid) begin
          // counter is exactly log2N bits, so N-1 + 1 wraps to 0
          wcnt_d = wcnt_q + ONE;
          if (wcnt_q == LAST) begin
            frame_done_d = 1'b1;
            state_d      = DRAIN;
          end
        end
      end
      DRAIN: begin
        mem_addrb = rcnt_q;
        rcnt_d    = rcnt_q + ONE;
        if (rcnt_q == LAST) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
    // buffer read data lags the issued address by one cycle
    out_valid_d = (state_q == DRAIN);
    out_last_d  = (state_q == DRAIN) && (rcnt_q == LAST);
  end

  assign mem_data_r = in_data_r;
  assign mem_data_i = in_data_i;
  assign out_data_r = mem_q_r;
  assign out_data_i = mem_q_i;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Directed bench for fft_bitrev_loader with a behavioural buffer memory.
module tb_fft_bitrev_loader;
  localparam int LG = 6;
  localparam int QW = 16;
  localparam int NN = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [QW-1:0] in_data_r = '0, in_data_i = '0;
  logic [LG-1:0] mem_addra, mem_addrb;
  logic          mem_we;
  logic [QW-1:0] mem_data_r, mem_data_i, mem_q_r, mem_q_i;
  logic          out_valid, out_last, frame_done;
  logic [QW-1:0] out_data_r, out_data_i;

  fft_bitrev_loader #(.log2N(LG), .Q(QW), .N(NN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data_r(in_data_r), .in_data_i(in_data_i),
    .mem_addra(mem_addra), .mem_addrb(mem_addrb), .mem_we(mem_we),
    .mem_data_r(mem_data_r), .mem_data_i(mem_data_i),
    .mem_q_r(mem_q_r), .mem_q_i(mem_q_i),
    .out_valid(out_valid), .out_last(out_last),
    .out_data_r(out_data_r), .out_data_i(out_data_i), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Buffer model: write holds the read register, otherwise 1-cycle read.
  logic [QW-1:0] mem_r [NN], mem_i [NN];
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mem_q_r <= '0;
      mem_q_i <= '0;
    end else if (mem_we) begin
      mem_r[mem_addra] <= mem_data_r;
      mem_i[mem_addra] <= mem_data_i;
    end else begin
      mem_q_r <= mem_r[mem_addrb];
      mem_q_i <= mem_i[mem_addrb];
    end
  end

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  // Output capture, sampled away from the active edge.
  logic [QW-1:0] qr[$], qi[$];
  logic          ql[$];
  int            qc[$];
  int            fd_cnt = 0;
  always @(negedge clk) begin
    if (out_valid) begin
      qr.push_back(out_data_r);
      qi.push_back(out_data_i);
      ql.push_back(out_last);
      qc.push_back(cyc);
    end
    if (frame_done) fd_cnt = fd_cnt + 1;
  end

  int errors = 0, checks = 0, last_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bitrev(input int k);
    logic [LG-1:0] a, r;
    a = LG'(k);
    for (int b = 0; b < LG; b++) r[LG-1-b] = a[b];
    return int'(r);
  endfunction

  function automatic logic [QW-1:0] exp_r(input int mode, input int base, input int k);
    return (mode == 1) ? 16'h8000 : QW'(base + k);
  endfunction
  function automatic logic [QW-1:0] exp_i(input int mode, input int base, input int k);
    return (mode == 1) ? 16'h7FFF : QW'(0 - (base + k));
  endfunction

  // Call at a negedge; drives n samples, one per accept, optional 1,0,0 gaps.
  task automatic send(input int mode, input int base, input int n, input bit gap, input bit hold);
    for (int k = 0; k < n; k++) begin
      in_valid  = 1'b1;
      in_data_r = exp_r(mode, base, k);
      in_data_i = exp_i(mode, base, k);
      last_cyc  = cyc;
      @(negedge clk);
      if (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
      end
    end
    if (!hold) in_valid = 1'b0;
  endtask

  // Output index a carries input sample bitrev(a).
  task automatic check_sym(input string nm, input int mode, input int base, input bit lat);
    int t;
    t = 0;
    while (qr.size() < NN && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_count_ok"}, 32'(qr.size() >= NN), 32'd1);
    if (qr.size() < NN) return;
    if (lat) chk({nm, "_latency"}, 32'(qc[0] - last_cyc), 32'd2);
    for (int a = 0; a < NN; a++) begin
      chk($sformatf("%s_r[%0d]", nm, a), 32'(qr.pop_front()), 32'(exp_r(mode, base, bitrev(a))));
      chk($sformatf("%s_i[%0d]", nm, a), 32'(qi.pop_front()), 32'(exp_i(mode, base, bitrev(a))));
      chk($sformatf("%s_last[%0d]", nm, a), 32'(ql.pop_front()), 32'(a == NN - 1));
      void'(qc.pop_front());
    end
  endtask

  initial begin
    int nrdy, nwe;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("idle_mem_we", 32'(mem_we), 32'd0);
    chk("idle_addra", 32'(mem_addra), 32'd0);
    chk("idle_addrb", 32'(mem_addrb), 32'd0);

    // continuous symbol 0..63
    send(0, 0, NN, 1'b0, 1'b0);
    check_sym("cont", 0, 0, 1'b1);
    chk("cont_frame_done", 32'(fd_cnt), 32'd1);

    // in_valid 1,0,0 pattern
    @(negedge clk);
    send(0, 0, NN, 1'b1, 1'b0);
    check_sym("gap", 0, 0, 1'b0);
    chk("gap_frame_done", 32'(fd_cnt), 32'd2);

    // in_valid held through DRAIN, then back-to-back symbol 100..163
    @(negedge clk);
    send(0, 0, NN, 1'b0, 1'b1);
    nrdy = 0;
    nwe  = 0;
    for (int t = 0; t < 200; t++) begin
      if (in_ready) break;
      nrdy++;
      if (mem_we) nwe++;
      @(negedge clk);
    end
    chk("hold_not_ready_cycles", 32'(nrdy), 32'd64);
    chk("hold_drain_writes", 32'(nwe), 32'd0);
    chk("hold_first_fill_addra", 32'(mem_addra), 32'd0);
    send(0, 100, NN, 1'b0, 1'b0);
    check_sym("b2b_sym1", 0, 0, 1'b0);
    check_sym("b2b_sym2", 0, 100, 1'b1);
    chk("b2b_frame_done", 32'(fd_cnt), 32'd4);

    // reset after 20 accepts, then a fresh symbol 200..263
    @(negedge clk);
    send(0, 50, 20, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      chk($sformatf("midrst_out_valid[%0d]", t), 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    chk("midrst_q_empty", 32'(qr.size()), 32'd0);
    @(negedge clk);
    send(0, 200, NN, 1'b0, 1'b0);
    check_sym("post_rst", 0, 200, 1'b1);

    // extreme values
    @(negedge clk);
    send(1, 0, NN, 1'b0, 1'b0);
    check_sym("extreme", 1, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global guard so the bench always terminates.
  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
